lcd_si_serializer: RTL
======================

# lcd_si_serializer

Serial-interface back end for the LCD path of the bicycle computer. It sits directly downstream of the LCD control stage: it takes that stage's byte stream, A0 flag and convert request, and shifts each byte MSB-first onto the LCD's SI/SCL pins under chip select. It returns the 4-bit phase `count` that paces the control stage's load and state-advance decisions.

## Interface
Parameters:
- `CLK_DIV`, default 4: system clocks per SCL half-period (one phase); legal range ≥1.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock and synchronous active-high reset, fixed.
- `convert_SI`  in  1  transmit request from control stage (level; sampled at frame boundaries).
- `data`  in  8  byte to shift; sampled only at frame load.
- `a0_in`  in  1  command(0)/data(1) flag; sampled with `data`.
- `count`  out  4  current phase 0..15; 0 while idle.
- `lcd_si`  out  1  serial data to LCD.
- `lcd_scl`  out  1  serial clock to LCD; idles high.
- `lcd_cs_n`  out  1  chip select, active low.
- `lcd_a0`  out  1  registered A0 to LCD, stable for the whole frame.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- States: IDLE, SHIFT.
- IDLE: `lcd_cs_n`=1, `lcd_scl`=1, `count`=0, `busy`=0. `convert_SI`=1 sampled at an edge → SHIFT; the same edge loads the shift register from `data`, latches `a0_in` into `lcd_a0`, and sets `count`=0 and the divider to 0.
- SHIFT: 16 phases, each `CLK_DIV` cycles. Bit i (i=0..7, MSB first) occupies phases 2i (SCL low) and 2i+1 (SCL high). `lcd_si` changes only on entry to an even phase. The LCD samples on the SCL rising edge (entry to odd phase).
- Frame end: on the last cycle of phase 15, `frame_done`=1.
  - If `convert_SI`=1 on that cycle: wrap to phase 0, reload `data`/`a0_in`, keep `lcd_cs_n` low (back-to-back frames, no gap).
  - Otherwise: return to IDLE and raise `lcd_cs_n`.
- `convert_SI` falling mid-frame does not abort the frame; the current frame always completes.
- `data` changing mid-frame has no effect. This gives the control stage's pipeline: a byte it writes during phase 0 of frame N is transmitted in frame N+1.
- Divider: counter 0..`CLK_DIV`-1 with width `$clog2(CLK_DIV)` (minimum 1 bit). The phase advances when the divider is at terminal count, and `count` increments modulo 16.

## Timing
- Reset values: `count`=0, `lcd_si`=0, `lcd_scl`=1, `lcd_cs_n`=1, `lcd_a0`=0, `busy`=0, `frame_done`=0, state IDLE.
- Latency: `convert_SI` high at edge k → `lcd_cs_n`=0, `lcd_scl`=0, `lcd_si`=data[7] after edge k.
- Frame length is exactly 16·`CLK_DIV` cycles. `busy` is high for all of them.
- All outputs are registered; no combinational path from inputs to outputs.
- `reset` asserted mid-frame: the next edge forces all reset values. The frame is aborted and `lcd_cs_n` rises immediately.
- `CLK_DIV`=1: SCL toggles every cycle and the phase is 1 cycle; the same rules apply.

## Structure
- Shared package `lcd_si_pkg`: state enum (IDLE, SHIFT), `LCD_SI_PHASES`=16, `LCD_SI_BYTE_W`=8. The existing LCD macro definitions for control codes stay where they are.
- One sub-module, `lcd_si_tick`: a parameterised divider emitting a one-cycle `phase_tick` at terminal count, with sync clear on frame load.

## Test plan
- Single frame, `CLK_DIV`=4, `data`=0xA5, `a0_in`=1, `convert_SI` pulsed 1 cycle:
  - SI sampled at 8 SCL rises = 1,0,1,0,0,1,0,1.
  - `lcd_a0`=1 for the frame.
  - `lcd_cs_n` low for exactly 64 cycles.
  - `frame_done` pulses once.
  - Returns to IDLE.
- Back-to-back frames, `convert_SI` held high, `data`=0x3C then 0xC3:
  - `lcd_cs_n` stays low across the boundary.
  - `count` wraps 15→0.
  - Second frame shifts the byte present at the wrap edge.
- Count sequencing: check that `count` steps 0..15, dwelling 4 cycles each, and that the control stage sees 0 at load and 1 on the next phase.
- Early drop: `convert_SI` falls at phase 5 → frame completes all 16 phases, then `lcd_cs_n`=1 and `count`=0.
- Reset mid-frame at phase 9 → next edge: `lcd_cs_n`=1, `lcd_scl`=1, `count`=0, `busy`=0; a new request restarts cleanly.
- `CLK_DIV`=1, `data`=0xFF, `a0_in`=0: 16-cycle frame, SCL toggles every cycle, SI constant 1, `lcd_a0`=0.

Source files
------------

// File: rtl/lcd_si_pkg.sv
// rtl/lcd_si_pkg.sv - shared types and constants for the LCD serial back end
package lcd_si_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } lcd_si_state_e;

   localparam int LCD_SI_PHASES = 16;
   localparam int LCD_SI_BYTE_W = 8;

endpackage

// File: rtl/lcd_si_tick.sv
// rtl/lcd_si_tick.sv - phase divider: pulses phase_tick on the last cycle of each phase
module lcd_si_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic phase_tick,
   output logic pre_tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   assign phase_tick = enable && (div == DIV_TC);

   // pre_tick: the following cycle will be the terminal cycle of a phase
   generate
      if (CLK_DIV == 1) begin : g_single
         assign pre_tick = 1'b1;
      end else begin : g_multi
         assign pre_tick = (div == DIV_W'(CLK_DIV - 2));
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         div <= '0;
      end else if (enable) begin
         if (div == DIV_TC)
            div <= '0;
         else
            div <= div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/lcd_si_serializer.sv
// rtl/lcd_si_serializer.sv - shifts control-stage bytes MSB-first onto the LCD SI/SCL pins
module lcd_si_serializer
   import lcd_si_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       convert_SI,
   input  logic [7:0] data,
   input  logic       a0_in,
   output logic [3:0] count,
   output logic       lcd_si,
   output logic       lcd_scl,
   output logic       lcd_cs_n,
   output logic       lcd_a0,
   output logic       busy,
   output logic       frame_done
);

   lcd_si_state_e            state, state_d;
   logic [3:0]               count_d;
   logic [LCD_SI_BYTE_W-1:0] shreg, shreg_d;
   logic                     si_d, scl_d, cs_n_d, a0_d, busy_d, done_d;
   logic                     load, last_phase, phase_tick, pre_tick;

   assign last_phase = (count == 4'(LCD_SI_PHASES - 1));

   // Loads happen from idle or at the wrap edge of a back-to-back frame
   assign load = convert_SI &&
                 ((state == IDLE) || (phase_tick && last_phase));

   lcd_si_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clock      (clock),
      .reset      (reset),
      .clear      (load),
      .enable     (state == SHIFT),
      .phase_tick (phase_tick),
      .pre_tick   (pre_tick)
   );

   always_comb begin
      state_d = state;
      count_d = count;
      shreg_d = shreg;
      si_d    = lcd_si;
      a0_d    = lcd_a0;
      case (state)
         IDLE: begin
            if (convert_SI)
               state_d = SHIFT;
         end
         SHIFT: begin
            if (phase_tick) begin
               if (last_phase) begin
                  count_d = '0;
                  if (!convert_SI)
                     state_d = IDLE;
               end else begin
                  count_d = count + 4'd1;
                  // leaving an odd (SCL high) phase: present the next bit
                  if (count[0]) begin
                     shreg_d = {shreg[LCD_SI_BYTE_W-2:0], 1'b0};
                     si_d    = shreg[LCD_SI_BYTE_W-2];
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         shreg_d = data;
         si_d    = data[LCD_SI_BYTE_W-1];
         a0_d    = a0_in;
         count_d = '0;
      end
      scl_d  = (state_d == SHIFT) ? count_d[0] : 1'b1;
      cs_n_d = (state_d != SHIFT);
      busy_d = (state_d == SHIFT);
      done_d = (state_d == SHIFT) && (count_d == 4'(LCD_SI_PHASES - 1)) && pre_tick;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         shreg      <= '0;
         lcd_si     <= 1'b0;
         lcd_scl    <= 1'b1;
         lcd_cs_n   <= 1'b1;
         lcd_a0     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_d;
         count      <= count_d;
         shreg      <= shreg_d;
         lcd_si     <= si_d;
         lcd_scl    <= scl_d;
         lcd_cs_n   <= cs_n_d;
         lcd_a0     <= a0_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

endmodule
